// File: rtl/spi2dac_mc.sv
// rtl/spi2dac_mc.sv - multi-channel MCP49x2 SPI DAC sequencer with one shared LDAC pulse
// Optional PWM mirror of channel 0 is built when SPI2DAC_MC_PWM_EN is defined.
module spi2dac_mc #(
  parameter int DATA_W  = 10,
  parameter int NCH     = 2,
  parameter int SCK_DIV = 2,
  parameter bit BUF     = 1'b0,
  parameter bit GAIN1X  = 1'b1
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    load,
  input  logic [NCH*DATA_W-1:0]   data_in,
  output logic                    dac_cs,
  output logic                    dac_sck,
  output logic                    dac_sdi,
  output logic                    dac_ld,
  output logic                    busy,
  output logic                    overrun,
  output logic                    pwm_out
);

  localparam int                CNT_W   = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCK_DIV - 1);
  localparam logic              LAST_CH = 1'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_LDAC} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sck;
  logic [15:0]             r_shift;
  logic [3:0]              r_bit;
  logic                    r_ch;
  logic [NCH*DATA_W-1:0]   r_data;
  logic                    r_overrun;
  logic                    w_wrap;
  logic                    w_accept;
  logic [2*DATA_W-1:0]     w_in_pad;
  logic [2*DATA_W-1:0]     w_data_pad;

  // Sample is left-justified into the 12-bit DAC field, low bits zero.
  function automatic logic [15:0] frame(input logic ch, input logic [2*DATA_W-1:0] src);
    logic [11:0] v;
    v = 12'(src[(ch ? DATA_W : 0) +: DATA_W]) << (12 - DATA_W);
    return {ch, BUF, GAIN1X, 1'b1, v};
  endfunction

  assign w_wrap     = (r_cnt == CNT_MAX);
  assign w_accept   = (r_state == S_IDLE) && load;
  assign w_in_pad   = (2*DATA_W)'(data_in);
  assign w_data_pad = (2*DATA_W)'(r_data);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (load) w_next = S_SHIFT;
      S_SHIFT: if (w_wrap && r_sck && (r_bit == 4'd15)) w_next = S_GAP;
      S_GAP:   if (w_wrap) w_next = (r_ch == LAST_CH) ? S_LDAC : S_SHIFT;
      S_LDAC:  if (w_wrap) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    dac_cs = 1'b1;
    dac_ld = 1'b1;
    busy   = 1'b1;
    case (r_state)
      S_IDLE:  busy   = 1'b0;
      S_SHIFT: dac_cs = 1'b0;
      S_LDAC:  dac_ld = 1'b0;
      default: ;
    endcase
  end

  assign dac_sck = r_sck;
  assign dac_sdi = r_shift[15];
  assign overrun = r_overrun;

  // The shift register empties itself over 16 falls, so SDI idles at 0 between frames.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_cnt     <= '0;
      r_sck     <= 1'b0;
      r_shift   <= '0;
      r_bit     <= '0;
      r_ch      <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (load && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_data  <= data_in;
            r_ch    <= 1'b0;
            r_shift <= frame(1'b0, w_in_pad);
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
          if (w_wrap) begin
            r_sck <= ~r_sck;
            if (r_sck) begin
              r_shift <= {r_shift[14:0], 1'b0};
              r_bit   <= r_bit + 4'd1;
            end
          end
        end
        S_GAP: begin
          r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
          if (w_wrap && (r_ch != LAST_CH)) begin
            r_ch    <= ~r_ch;
            r_shift <= frame(~r_ch, w_data_pad);
            r_bit   <= '0;
            r_sck   <= 1'b0;
          end
        end
        default: r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      endcase
    end
  end

`ifdef SPI2DAC_MC_PWM_EN
  logic [DATA_W-1:0] r_pwm_cnt;
  logic [DATA_W-1:0] r_pwm_cmp;
  logic              r_pwm_pend;
  logic              r_pwm;

  // New compare values only land at a counter wrap so no period is cut short.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_pwm_cnt  <= '0;
      r_pwm_cmp  <= '0;
      r_pwm_pend <= 1'b0;
      r_pwm      <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + DATA_W'(1);
      r_pwm     <= (r_pwm_cmp > r_pwm_cnt);
      if (w_accept) begin
        r_pwm_pend <= 1'b1;
      end else if (r_pwm_pend && (r_pwm_cnt == '1)) begin
        r_pwm_cmp  <= r_data[DATA_W-1:0];
        r_pwm_pend <= 1'b0;
      end
    end
  end

  assign pwm_out = r_pwm;
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi2dac_mc.sv
// tb/tb_spi2dac_mc.sv - randomized bench for spi2dac_mc against a cycle-timeline model
module tb_spi2dac_mc;
  localparam int DATA_W = 10;
  localparam int NCH    = 2;
  localparam int SD     = 2;
  localparam int PER    = 33 * SD;
  localparam int TOTAL  = NCH * PER + SD;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  load = 1'b0;
  logic [NCH*DATA_W-1:0] data_in = '0;
  logic dac_cs, dac_sck, dac_sdi, dac_ld, busy, overrun, pwm_out;

  spi2dac_mc #(.DATA_W(DATA_W), .NCH(NCH), .SCK_DIV(SD), .BUF(1'b0), .GAIN1X(1'b1)) dut (
    .CLOCK_50(clk), .RESET(rst), .load(load), .data_in(data_in),
    .dac_cs(dac_cs), .dac_sck(dac_sck), .dac_sdi(dac_sdi), .dac_ld(dac_ld),
    .busy(busy), .overrun(overrun), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time index since the accepting edge, frames as plain arithmetic.
  bit          m_active = 0;
  int          m_t = 0;
  bit          m_ovr = 0;
  logic [15:0] m_frame [NCH];

  function automatic logic [15:0] mk_frame(input int k, input logic [DATA_W-1:0] d);
    int v;
    v = (k % 2) * 32768 + 0 * 16384 + 8192 + 4096 + int'(d) * (1 << (12 - DATA_W));
    return 16'(v);
  endfunction

  always @(posedge clk) begin
    bit was_busy;
    if (rst) begin
      m_active = 0;
      m_t      = 0;
      m_ovr    = 0;
    end else begin
      was_busy = m_active;
      if (m_active) begin
        m_t++;
        if (m_t == TOTAL) m_active = 0;
      end
      if (load) begin
        if (was_busy) m_ovr = 1;
        else begin
          m_active = 1;
          m_t      = 0;
          for (int k = 0; k < NCH; k++) m_frame[k] = mk_frame(k, data_in[k*DATA_W +: DATA_W]);
        end
      end
    end
  end

  bit          chk_en = 0;
  logic        prev_sck = 0, prev_cs = 1;
  logic [15:0] cap = '0;
  int          nbits = 0;
  logic [15:0] words[$];
  int          busy_cnt = 0, ld_cnt = 0, pwm_cnt = 0;
  int          mc, mr;
  logic        e_cs, e_sck, e_ld, e_busy, e_sdi;
  bit          sdi_valid;

  always @(negedge clk) begin
    if (chk_en) begin
      e_cs = 1; e_sck = 0; e_ld = 1; e_busy = 0; e_sdi = 0; sdi_valid = 0;
      if (m_active) begin
        e_busy = 1;
        if (m_t < NCH * PER) begin
          mc = m_t / PER;
          mr = m_t % PER;
          if (mr < 32 * SD) begin
            e_cs      = 0;
            e_sck     = 1'((mr / SD) % 2);
            e_sdi     = m_frame[mc][15 - mr / (2 * SD)];
            sdi_valid = 1;
          end
        end else begin
          e_ld = 0;
        end
      end
      chk("cs", dac_cs, e_cs);
      chk("sck", dac_sck, e_sck);
      chk("ld", dac_ld, e_ld);
      chk("busy", busy, e_busy);
      chk("overrun", overrun, m_ovr);
      if (sdi_valid) chk("sdi", dac_sdi, e_sdi);
`ifndef SPI2DAC_MC_PWM_EN
      chk("pwm_off", pwm_out, 1'b0);
`endif
      if (dac_sck && !prev_sck) begin
        cap = {cap[14:0], dac_sdi};
        nbits++;
      end
      if (dac_cs && !prev_cs) begin
        if (nbits == 16) words.push_back(cap);
        nbits = 0;
      end
      if (busy) busy_cnt++;
      if (!dac_ld) ld_cnt++;
      if (pwm_out) pwm_cnt++;
      prev_sck = dac_sck;
      prev_cs  = dac_cs;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [NCH*DATA_W-1:0] d);
    data_in = d;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy !== 1'b0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1;
    tick(2);
    chk("rst_cs", dac_cs, 1'b1);
    chk("rst_sck", dac_sck, 1'b0);
    chk("rst_sdi", dac_sdi, 1'b0);
    chk("rst_ld", dac_ld, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_pwm", pwm_out, 1'b0);
    rst = 1'b0;
    tick(100);

    // Single transfer with known frames
    words.delete(); busy_cnt = 0; ld_cnt = 0;
    pulse_load({10'h155, 10'h2AB});
    wait_idle();
    chk("busy_len", busy_cnt, 134);
    chk("ld_len", ld_cnt, 2);
    chk("nwords", words.size(), 2);
    if (words.size() == 2) begin
      chk("word0", words[0], 16'h3AAC);
      chk("word1", words[1], 16'hB554);
    end
    tick(5);

    // Load while busy is ignored and sets overrun
    words.delete();
    pulse_load({10'h3FF, 10'h000});
    tick(19);
    pulse_load({10'h0AA, 10'h155});
    chk("ovr_set", overrun, 1'b1);
    wait_idle();
    chk("ovr_nwords", words.size(), 2);
    if (words.size() == 2) begin
      chk("ovr_word0", words[0], 16'h3000);
      chk("ovr_word1", words[1], 16'hBFFC);
    end
    tick(10);
    chk("ovr_sticky", overrun, 1'b1);
    do_reset();
    chk("ovr_clear", overrun, 1'b0);

    // Back-to-back transfers
    words.delete();
    pulse_load({10'h001, 10'h200});
    wait_idle();
    pulse_load(20'($urandom));
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_ovr", overrun, 1'b0);
    wait_idle();
    chk("b2b_nwords", words.size(), 4);
    if (words.size() == 4) chk("b2b_word0", words[0], 16'h3800);

    // Reset mid-transfer
    tick(3);
    ld_cnt = 0;
    pulse_load(20'($urandom));
    tick(39);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_cs", dac_cs, 1'b1);
    chk("mid_sck", dac_sck, 1'b0);
    chk("mid_ld", dac_ld, 1'b1);
    chk("mid_busy", busy, 1'b0);
    tick(200);
    chk("mid_no_ld", ld_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      pulse_load(20'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(1, 120));
        pulse_load(20'($urandom));
      end
      if ($urandom_range(0, 7) == 0) begin
        tick($urandom_range(1, 130));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      wait_idle();
      tick($urandom_range(0, 3));
    end

`ifdef SPI2DAC_MC_PWM_EN
    do_reset();
    pulse_load({10'h000, 10'd256});
    wait_idle();
    tick(2100);
    pwm_cnt = 0;
    tick(1024);
    chk("pwm_duty", pwm_cnt, 256);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
